// File: rtl/read_stream.sv
// read_stream: two-entry skid buffer that turns a FIFO read port
// (empty flag + combinational read data + pop strobe) into a
// valid/ready stream with registered data and valid.
// Optional feature macro: READ_STREAM_LEVEL_EN adds the 2-bit level
// output reporting how many words are buffered (0..2).
module read_stream #(
    parameter int data_size = 8
) (
    input  logic                 read_clk,
    input  logic                 read_rst_n,
    input  logic                 fifo_empty,
    input  logic [data_size-1:0] rd_data,
    output logic                 read_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [data_size-1:0] m_data
`ifdef READ_STREAM_LEVEL_EN
    ,
    output logic [1:0]           level
`endif
);

    // Encoding doubles as the buffered-word count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [data_size-1:0] out_reg_q, out_reg_d;
    logic [data_size-1:0] skid_reg_q, skid_reg_d;
    logic                 push;
    logic                 pop;

    // Pop request depends only on registered state and the FIFO flag, so
    // there is no combinational path from m_ready back into the FIFO.
    // Reset gates it off because EMPTY alone would otherwise request data.
    always_comb begin
        read_en = read_rst_n && !fifo_empty && (state_q != TWO);
        m_valid = (state_q != EMPTY);
        m_data  = out_reg_q;
        push    = read_en;
        pop     = m_valid && m_ready;
    end

    // Next-state and data-register selection for the skid buffer.
    always_comb begin
        state_d    = state_q;
        out_reg_d  = out_reg_q;
        skid_reg_d = skid_reg_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    out_reg_d = rd_data;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    out_reg_d = rd_data;
                end else if (push) begin
                    skid_reg_d = rd_data;
                    state_d    = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // read_en is low here, so only a pop can happen.
                if (pop) begin
                    out_reg_d = skid_reg_q;
                    state_d   = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and data registers; reset discards any buffered words at once.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            state_q    <= EMPTY;
            out_reg_q  <= '0;
            skid_reg_q <= '0;
        end else begin
            state_q    <= state_d;
            out_reg_q  <= out_reg_d;
            skid_reg_q <= skid_reg_d;
        end
    end

`ifdef READ_STREAM_LEVEL_EN
    // Level is the registered state read as a count.
    always_comb begin
        level = 2'(state_q);
    end
`endif

endmodule

// File: tb/tb_read_stream.sv
// Self-checking bench for read_stream. A queue-based model of a
// two-deep buffer (not the FSM) predicts read_en, m_valid, m_data and
// level each cycle; the source FIFO is a queue popped on read_en.
module tb_read_stream;

    localparam int DW = 16;

    logic          read_clk = 1'b0;
    logic          read_rst_n;
    logic          fifo_empty;
    logic [DW-1:0] rd_data;
    logic          read_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef READ_STREAM_LEVEL_EN
    logic [1:0]    level;
`endif

    read_stream #(.data_size(DW)) dut (
        .read_clk   (read_clk),
        .read_rst_n (read_rst_n),
        .fifo_empty (fifo_empty),
        .rd_data    (rd_data),
        .read_en    (read_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef READ_STREAM_LEVEL_EN
        ,
        .level      (level)
`endif
    );

    always #5 read_clk = ~read_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] src[$];      // words waiting in the upstream FIFO
    logic [DW-1:0] buf_q[$];    // words the block should be holding
    logic [DW-1:0] out_log[$];  // words accepted by the consumer

    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit want_empty, input bit rdy);
        bit exp_re;
        bit do_pop;
        fifo_empty = want_empty || (src.size() == 0);
        m_ready    = rdy;
        rd_data    = (src.size() != 0) ? src[0] : '0;
        #3;
        exp_re = !fifo_empty && (buf_q.size() < 2);
        check("read_en", 32'(read_en), 32'(exp_re));
        check("m_valid", 32'(m_valid), 32'(buf_q.size() != 0));
        if (buf_q.size() != 0) check("m_data", 32'(m_data), 32'(buf_q[0]));
        if (prev_stall && m_valid) check("hold", 32'(m_data), 32'(prev_data));
`ifdef READ_STREAM_LEVEL_EN
        check("level", 32'(level), buf_q.size());
`endif
        do_pop     = (buf_q.size() != 0) && rdy;
        prev_stall = (buf_q.size() != 0) && !rdy;
        prev_data  = m_data;
        @(posedge read_clk);
        if (do_pop) out_log.push_back(buf_q.pop_front());
        if (exp_re) buf_q.push_back(src.pop_front());
        #1;
    endtask

    initial begin
        int guard;

        // Reset with words available: nothing may be requested or shown.
        read_rst_n = 1'b0;
        fifo_empty = 1'b0;
        m_ready    = 1'b0;
        rd_data    = '0;
        repeat (2) @(posedge read_clk);
        #1;
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
`ifdef READ_STREAM_LEVEL_EN
        check("rst_level", 32'(level), 32'd0);
`endif
        read_rst_n = 1'b1;
        #1;
        check("release_read_en", 32'(read_en), 32'd1);
        @(posedge read_clk);  // rd_data=0 taken by that edge? model it
        if (read_en) buf_q.push_back('0);
        #1;
        fifo_empty = 1'b1;
        step(1'b1, 1'b1);     // drain the zero word
        step(1'b1, 1'b1);
        out_log.delete();

        // Streaming at full rate: 0x11, 0x22, 0x33.
        src = '{16'h0011, 16'h0022, 16'h0033};
        repeat (5) step(1'b0, 1'b1);
        check("seq_count", out_log.size(), 32'd3);
        if (out_log.size() == 3) begin
            check("seq0", 32'(out_log[0]), 32'h11);
            check("seq1", 32'(out_log[1]), 32'h22);
            check("seq2", 32'(out_log[2]), 32'h33);
        end
        out_log.delete();

        // Stall fills both registers; read_en drops though the FIFO has data.
        src = '{16'h00A1, 16'h00A2, 16'h00A3};
        repeat (3) step(1'b0, 1'b0);
        check("two_read_en", 32'(read_en), 32'd0);
        check("two_m_data", 32'(m_data), 32'hA1);
        repeat (2) step(1'b1, 1'b1);
        check("stall_count", out_log.size(), 32'd2);
        if (out_log.size() == 2) begin
            check("stall0", 32'(out_log[0]), 32'hA1);
            check("stall1", 32'(out_log[1]), 32'hA2);
        end
        src.delete();
        step(1'b1, 1'b0);
        out_log.delete();

        // Single word drains while the FIFO is empty.
        src = '{16'h005C};
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("drain_m_valid", 32'(m_valid), 32'd0);
        check("drain_read_en", 32'(read_en), 32'd0);
        check("drain_count", out_log.size(), 32'd1);
        if (out_log.size() == 1) check("drain0", 32'(out_log[0]), 32'h5C);
        out_log.delete();

        // Random flow control over 1000 words.
        for (int i = 0; i < 1000; i++) src.push_back(DW'(i));
        guard = 0;
        while (out_log.size() < 1000 && guard < 20000) begin
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
            guard++;
        end
        check("rand_count", out_log.size(), 32'd1000);
        for (int i = 0; i < out_log.size(); i++) check("rand_order", 32'(out_log[i]), i);
        src.delete();
        out_log.delete();

        // Reset while holding two words.
        src = '{16'h0001, 16'h0002, 16'h0003};
        repeat (2) step(1'b0, 1'b0);
        check("pre_rst_m_valid", 32'(m_valid), 32'd1);
        #2;
        read_rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_m_data", 32'(m_data), 32'd0);
        check("mid_rst_read_en", 32'(read_en), 32'd0);
`ifdef READ_STREAM_LEVEL_EN
        check("mid_rst_level", 32'(level), 32'd0);
`endif
        buf_q.delete();
        src.delete();
        prev_stall = 1'b0;
        fifo_empty = 1'b1;
        repeat (2) @(posedge read_clk);
        #1;
        read_rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b1);
        check("no_stale", out_log.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_stream.md
READ_STREAM -- requirements
Module: read_stream

Interface
REQ-001 SHALL have parameter data_size, default 8, giving the width of FIFO read data and stream data in bits.
REQ-002 SHALL have port read_clk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port read_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port fifo_empty  input  1  FIFO empty flag from the read pointer controller, in the read_clk domain.
REQ-005 SHALL have port rd_data  input  data_size  memory word at the current read pointer; valid combinationally in the same cycle.
REQ-006 SHALL have port read_en  output  1  pop request to the read pointer controller; advances the read pointer on the next read_clk edge.
REQ-007 SHALL have port m_valid  output  1  stream data valid, registered.
REQ-008 SHALL have port m_ready  input  1  downstream consumer ready.
REQ-009 SHALL have port m_data  output  data_size  stream data, registered; equals the output register out_reg.
REQ-010 SHALL have port level  output  2  buffered entry count 0..2; present only per REQ-027.

Function
REQ-011 SHALL hold two data registers (out_reg and skid_reg) and a 3-state FSM: EMPTY (0 entries), ONE (out_reg holds data), TWO (both registers hold data, out_reg is older).
REQ-012 SHALL define pop = m_valid AND m_ready, and push = read_en.
REQ-013 SHALL drive read_en = NOT fifo_empty AND state != TWO; it is combinational from registered state and fifo_empty, with no path from m_ready.
REQ-014 SHALL drive m_valid high exactly when state is ONE or TWO.
REQ-015 In EMPTY, a push SHALL load out_reg <= rd_data and move to ONE; otherwise the block SHALL stay in EMPTY.
REQ-016 In ONE, push with pop SHALL load out_reg <= rd_data and stay in ONE; push alone SHALL load skid_reg <= rd_data and move to TWO; pop alone SHALL move to EMPTY; neither SHALL hold.
REQ-017 In TWO, pop SHALL load out_reg <= skid_reg and move to ONE; otherwise the block SHALL hold; push cannot occur in TWO.
REQ-018 SHALL keep m_data stable while m_valid is high and m_ready is low (AXI-style hold rule).
REQ-019 SHALL deliver words in FIFO order with no loss or duplication under any m_ready pattern.
REQ-020 Latency: a word SHALL appear on m_data/m_valid one read_clk cycle after the cycle in which its read_en was high.
REQ-021 Throughput: with fifo_empty low and m_ready held high, the block SHALL sustain one word per cycle in state ONE.
REQ-022 With fifo_empty high, read_en SHALL be low, and buffered words SHALL still drain on pop.
REQ-023 SHALL leave skid_reg unchanged in all cases not listed in REQ-016.

Reset
REQ-024 While read_rst_n is low, the block SHALL hold state at EMPTY, out_reg and skid_reg at 0, m_valid at 0, m_data at 0 and level at 0; read_en SHALL be forced to 0.
REQ-025 Reset asserted mid-operation SHALL discard buffered words immediately; the block SHALL resume from EMPTY on the first read_clk edge after deassertion.

Configuration
REQ-026 SHALL recognise the macro READ_STREAM_LEVEL_EN.
REQ-027 With READ_STREAM_LEVEL_EN defined, the level port SHALL exist and equal 0, 1 or 2 for EMPTY, ONE or TWO respectively, registered with the FSM.
REQ-028 Without READ_STREAM_LEVEL_EN defined, the level port SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Reset with read_rst_n=0 and fifo_empty=0 -> read_en=0, m_valid=0, m_data=0; first edge after release -> read_en=1.
REQ-030 fifo_empty=0, rd_data sequence 0x11, 0x22, 0x33, m_ready=1 -> m_data 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after its read_en.
REQ-031 m_ready=0 with words 0xA1, 0xA2 available -> state TWO, read_en=0, m_data holds 0xA1; m_ready=1 for 2 cycles -> 0xA1 then 0xA2, no loss.
REQ-032 ONE state holding 0x5C, fifo_empty=1, m_ready=1 -> one beat 0x5C, then m_valid=0, read_en=0.
REQ-033 Random m_ready and fifo_empty over 1000 words 0..999 -> output sequence exactly 0..999; m_data stable whenever m_valid=1 and m_ready=0.
REQ-034 Reset asserted in TWO holding 0x01, 0x02 -> m_valid=0 immediately; after release no stale word appears; level=0 when READ_STREAM_LEVEL_EN is defined.
